vga_pipeline_ctrl: RTL
======================

Name: vga_pipeline_ctrl

Overview:
- Single-clock, parametrised successor to the VGA controller.
- Generates VGA timing from one pixel clock: no derived line clock, so the vertical counter is clock-enabled rather than separately clocked.
- Produces frame-buffer ROM addresses for a square image window, including a 4x4 tile-zoom mode.
- Delays sync, blank and frame markers so they line up with ROM data of configurable read latency. Sits between the image ROM and the DAC/VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
IMG_DIM, 256, image side in pixels; power of 2
IMG_X0, 192, window left column
IMG_Y0, 112, window top line
GRID, 4, tiles per side in zoom mode; power of 2 dividing IMG_DIM
ROM_LAT, 1, ROM read latency in cycles; legal range 1..4
ADDR_W, 18, address width; must be >= 2*log2(IMG_DIM)
BG_COLOR, 8'h20, grey level inside active area but outside window

Ports:
clock_25  in  1  pixel clock
reset  in  1  synchronous, active-high
quadrant  in  5  0 = full image; 1..GRID*GRID = zoomed tile; other values are treated as 0
data_drom  in  8  grey pixel from ROM, valid ROM_LAT cycles after address
address  out  ADDR_W  ROM address
red  out  8  colour
green  out  8  colour
blue  out  8  colour
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
n_blank  out  1  1 = active video
frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters: h runs 0..H_TOT-1 and wraps to 0. v increments when h wraps, runs 0..V_TOT-1 and wraps to 0.
- Quadrant latch:
  - quadrant is sampled into q_reg only on the cycle where h=0 and v=0.
  - Mid-frame changes have no effect until the next frame.
- In-window test: a pixel is in-window if IMG_X0 <= h < IMG_X0+IMG_DIM and IMG_Y0 <= v < IMG_Y0+IMG_DIM, with offsets dx = h-IMG_X0, dy = v-IMG_Y0.
- Source coordinates:
  - q_reg = 0: sx = dx, sy = dy.
  - q_reg = k in 1..GRID*GRID: T = IMG_DIM/GRID, row = (k-1)/GRID, col = (k-1)%GRID, sx = col*T + dx/GRID, sy = row*T + dy/GRID. Each source pixel is replicated GRID x GRID.
- Address generation:
  - Stage 1 (registered): address = sy*IMG_DIM + sx, zero-extended to ADDR_W.
  - Outside the window, address = 0.
- Pipeline latency: LAT = ROM_LAT+2 cycles from counter state (h,v) to outputs for that pixel.
  - address for (h,v) appears 1 cycle after the counter state.
  - data_drom for that address arrives ROM_LAT cycles later.
  - The output register takes 1 further cycle.
- Timing signals:
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
  - vsync uses the same rule on v with the V_ parameters.
  - n_blank = (h<H_ACTIVE && v<V_ACTIVE).
  - frame_start = (h=0 && v=0).
  - All four are computed at stage 0 and passed through a LAT-deep shift register together with the in-window flag.
- Colour selection at the output stage:
  - n_blank=0: red = green = blue = 0.
  - active and in-window: red = green = blue = data_drom.
  - active and out-of-window: red = green = blue = BG_COLOR.
- Reset values (synchronous, highest priority):
  - h, v, q_reg, address, RGB, frame_start and n_blank are 0.
  - hsync and vsync are ~SYNC_POL.
  - All delay-line stages are flushed to the inactive values.
  - The first valid frame_start occurs LAT cycles after reset deasserts.
- Reset mid-frame: all of the above takes effect on the next edge, with no partial sync pulse extended.

Test Plan:
- Reset held 3 cycles, then released -> outputs hold reset values for LAT=3 cycles, then frame_start=1 for exactly 1 cycle.
- Free-run 2 frames (defaults) -> hsync period 800 cycles with 96 low; vsync period 420000 cycles with 1600 low; n_blank high 640 of 800 cycles on lines 0..479.
- q=0 -> (h,v)=(192,112) gives address 0; (447,367) gives 65535; (191,112) gives 0 with BG_COLOR on RGB.
- q=6 latched -> (192,112) and (195,115) both give address 16448; (196,112) gives 16449; (192,116) gives 16704.
- q changed 0->6 at v=200 -> addresses stay in full-image mode for the rest of the frame; zoom applies from the next frame's line 0.
- ROM_LAT=3 with a model returning data = address[7:0] after 3 cycles -> RGB at the output for pixel (200,112) equals 8; hsync/n_blank edges shift by exactly 5 cycles from counter values.

Source files
------------

// File: rtl/vga_pipeline_ctrl.sv
// Single-clock VGA timing, frame-buffer addressing and output stage.
// Sync/blank/frame markers are delayed to line up with ROM read data.
module vga_pipeline_ctrl #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter logic       SYNC_POL = 1'b0,
  parameter int         IMG_DIM  = 256,
  parameter int         IMG_X0   = 192,
  parameter int         IMG_Y0   = 112,
  parameter int         GRID     = 4,
  parameter int         ROM_LAT  = 1,
  parameter int         ADDR_W   = 18,
  parameter logic [7:0] BG_COLOR = 8'h20
) (
  input  logic              clock_25,
  input  logic              reset,
  input  logic [4:0]        quadrant,
  input  logic [7:0]        data_drom,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              n_blank,
  output logic              frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int DW    = $clog2(IMG_DIM);
  localparam int GW    = $clog2(GRID);
  localparam int GW2   = 2 * GW;
  localparam int LAT   = ROM_LAT + 2;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_X0   = HW'(IMG_X0);
  localparam logic [HW-1:0] H_X1   = HW'(IMG_X0 + IMG_DIM);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_Y0   = VW'(IMG_Y0);
  localparam logic [VW-1:0] V_Y1   = VW'(IMG_Y0 + IMG_DIM);

  localparam logic [5:0] Q_MAX = 6'(GRID * GRID);

  typedef struct packed {
    logic hs;
    logic vs;
    logic nb;
    logic fs;
  } tm_t;

  localparam tm_t TM_IDLE = '{
    hs: ~SYNC_POL,
    vs: ~SYNC_POL,
    nb: 1'b0,
    fs: 1'b0
  };

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [4:0]        q_reg_q, q_reg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        pix_q, pix_d;
  tm_t               dl_q [LAT];
  tm_t               dl_d [LAT];
  logic [LAT-2:0]    win_q, win_d;

  logic              h_wrap;
  logic              frame0;
  logic              q_ok;
  logic [4:0]        q_cur;
  logic              win0;
  tm_t               tm0;
  logic [DW-1:0]     dx, dy;
  logic [DW-1:0]     sx, sy;
  logic [GW2-1:0]    tile;
  logic [GW-1:0]     t_row, t_col;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_comb begin
    frame0  = (h_q == '0) && (v_q == '0);
    q_ok    = (quadrant != 5'd0) && ({1'b0, quadrant} <= Q_MAX);
    q_reg_d = q_reg_q;
    if (frame0) begin
      q_reg_d = q_ok ? quadrant : 5'd0;
    end
    // pixel (0,0) already belongs to the newly latched frame
    q_cur = frame0 ? q_reg_d : q_reg_q;
  end

  always_comb begin
    win0 = (h_q >= H_X0) && (h_q < H_X1)
        && (v_q >= V_Y0) && (v_q < V_Y1);
    tm0.hs = ((h_q >= H_SS) && (h_q < H_SE))
           ? SYNC_POL : ~SYNC_POL;
    tm0.vs = ((v_q >= V_SS) && (v_q < V_SE))
           ? SYNC_POL : ~SYNC_POL;
    tm0.nb = (h_q < H_ACT) && (v_q < V_ACT);
    tm0.fs = frame0;
  end

  always_comb begin
    dx    = DW'(h_q - H_X0);
    dy    = DW'(v_q - V_Y0);
    tile  = GW2'(q_cur - 5'd1);
    t_row = tile[GW2-1:GW];
    t_col = tile[GW-1:0];
    sx    = dx;
    sy    = dy;
    // zoom: tile origin in the top bits, offset/GRID below
    if (q_cur != 5'd0) begin
      sx = {t_col, dx[DW-1:GW]};
      sy = {t_row, dy[DW-1:GW]};
    end
    addr_d = win0 ? ADDR_W'({sy, sx}) : '0;
  end

  always_comb begin
    dl_d[0] = tm0;
    for (int i = 1; i < LAT; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  always_comb begin
    win_d = {win_q[LAT-3:0], win0};
  end

  // dl stage LAT-2 lines up with the ROM data for its pixel
  always_comb begin
    pix_d = 8'h00;
    if (dl_q[LAT-2].nb) begin
      pix_d = win_q[LAT-2] ? data_drom : BG_COLOR;
    end
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      q_reg_q <= '0;
      addr_q  <= '0;
      pix_q   <= '0;
      win_q   <= '0;
      for (int i = 0; i < LAT; i++) begin
        dl_q[i] <= TM_IDLE;
      end
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      q_reg_q <= q_reg_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      win_q   <= win_d;
      for (int i = 0; i < LAT; i++) begin
        dl_q[i] <= dl_d[i];
      end
    end
  end

  assign address     = addr_q;
  assign red         = pix_q;
  assign green       = pix_q;
  assign blue        = pix_q;
  assign hsync       = dl_q[LAT-1].hs;
  assign vsync       = dl_q[LAT-1].vs;
  assign n_blank     = dl_q[LAT-1].nb;
  assign frame_start = dl_q[LAT-1].fs;

endmodule
